// File: rtl/mem_arbiter.sv
// mem_arbiter: owns the byte-wide RAM/IO port, serving IF word fetches and LSB loads/stores.
// Rev 1.0. Build option MEM_ARB_RR_EN: round-robin tie-break (default: LSB wins ties).
`default_nettype none

module mem_arbiter #(
    parameter int         ADDR_W = 32,
    parameter logic [1:0] IO_HI  = 2'b11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              clear,
    input  logic              io_buffer_full,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [31:0]       if_data,
    input  logic              lsb_req,
    input  logic [ADDR_W-1:0] lsb_addr,
    input  logic [ADDR_W-1:0] lsb_imm,
    input  logic [31:0]       lsb_val,
    input  logic [5:0]        lsb_opt,
    output logic              lsb_done,
    output logic              cdb_ok,
    output logic [3:0]        cdb_en,
    output logic [31:0]       cdb_val
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_base;
    logic [2:0]        r_n;
    logic [2:0]        r_idx;
    logic [1:0]        r_cap;
    logic              r_first;
    logic              r_is_if;
    logic [2:0]        r_f3;
    logic [31:0]       r_val;
    logic [3:0]        r_tag;
    logic [31:0]       r_buf;

    logic [7:0]        r_mem_dout;
    logic [ADDR_W-1:0] r_mem_a;
    logic              r_mem_wr;
    logic              r_if_done;
    logic [31:0]       r_if_data;
    logic              r_lsb_done;
    logic              r_cdb_ok;
    logic [3:0]        r_cdb_en;
    logic [31:0]       r_cdb_val;

    logic [ADDR_W-1:0] w_eaddr;
    logic [ADDR_W-1:0] w_next_addr;
    logic              w_lsb_store;
    logic [2:0]        w_lsb_n;
    logic              w_pick_if;
    logic              w_grant_if;
    logic              w_grant_lsb;
    logic              w_io_grant;
    logic              w_io_next;
    logic [7:0]        w_store_byte;
    logic [31:0]       w_buf_cap;
    logic [31:0]       w_ext;

    assign mem_dout = r_mem_dout;
    assign mem_a    = r_mem_a;
    assign mem_wr   = r_mem_wr;
    assign if_done  = r_if_done;
    assign if_data  = r_if_data;
    assign lsb_done = r_lsb_done;
    assign cdb_ok   = r_cdb_ok;
    assign cdb_en   = r_cdb_en;
    assign cdb_val  = r_cdb_val;

    assign w_eaddr     = lsb_addr + lsb_imm;
    assign w_next_addr = r_base + ADDR_W'(r_idx);
    assign w_lsb_store = (lsb_opt[5:3] == 3'b111);
    assign w_io_grant  = (w_eaddr[17:16] == IO_HI) && io_buffer_full;
    assign w_io_next   = (w_next_addr[17:16] == IO_HI) && io_buffer_full;

`ifdef MEM_ARB_RR_EN
    // High when IF holds priority for the next tie; flips to the loser on every grant.
    logic r_rr_if;
    assign w_pick_if = if_req && (!lsb_req || r_rr_if);
`else
    assign w_pick_if = if_req && !lsb_req;
`endif

    // Grants are withheld while clear is high so a flushed requester cannot slip in.
    assign w_grant_if  = (r_state == S_IDLE) && !clear && w_pick_if;
    assign w_grant_lsb = (r_state == S_IDLE) && !clear && lsb_req && !w_pick_if;

    always_comb begin
        w_lsb_n = 3'd4;
        case (lsb_opt[1:0])
            2'b00:   w_lsb_n = 3'd1;
            2'b01:   w_lsb_n = 3'd2;
            default: w_lsb_n = 3'd4;
        endcase
    end

    always_comb begin
        w_store_byte = r_val[7:0];
        case (r_idx[1:0])
            2'd0:    w_store_byte = r_val[7:0];
            2'd1:    w_store_byte = r_val[15:8];
            2'd2:    w_store_byte = r_val[23:16];
            default: w_store_byte = r_val[31:24];
        endcase
    end

    // Word as it will look once the byte arriving this cycle is merged in.
    always_comb begin
        w_buf_cap = r_buf;
        case (r_cap)
            2'd0:    w_buf_cap[7:0]   = mem_din;
            2'd1:    w_buf_cap[15:8]  = mem_din;
            2'd2:    w_buf_cap[23:16] = mem_din;
            default: w_buf_cap[31:24] = mem_din;
        endcase
    end

    always_comb begin
        w_ext = w_buf_cap;
        case (r_f3)
            3'b000:  w_ext = {{24{w_buf_cap[7]}}, w_buf_cap[7:0]};
            3'b001:  w_ext = {{16{w_buf_cap[15]}}, w_buf_cap[15:0]};
            3'b100:  w_ext = {24'd0, w_buf_cap[7:0]};
            3'b101:  w_ext = {16'd0, w_buf_cap[15:0]};
            default: w_ext = w_buf_cap;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_base     <= '0;
            r_n        <= 3'd0;
            r_idx      <= 3'd0;
            r_cap      <= 2'd0;
            r_first    <= 1'b0;
            r_is_if    <= 1'b0;
            r_f3       <= 3'd0;
            r_val      <= 32'd0;
            r_tag      <= 4'd0;
            r_buf      <= 32'd0;
            r_mem_dout <= 8'd0;
            r_mem_a    <= '0;
            r_mem_wr   <= 1'b0;
            r_if_done  <= 1'b0;
            r_if_data  <= 32'd0;
            r_lsb_done <= 1'b0;
            r_cdb_ok   <= 1'b0;
            r_cdb_en   <= 4'd0;
            r_cdb_val  <= 32'd0;
`ifdef MEM_ARB_RR_EN
            r_rr_if    <= 1'b1;
`endif
        end else if (rdy) begin
            r_if_done  <= 1'b0;
            r_lsb_done <= 1'b0;
            r_cdb_ok   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant_if) begin
                        r_is_if  <= 1'b1;
                        r_base   <= if_addr;
                        r_n      <= 3'd4;
                        r_idx    <= 3'd1;
                        r_cap    <= 2'd0;
                        r_first  <= 1'b1;
                        r_mem_a  <= if_addr;
                        r_mem_wr <= 1'b0;
                        r_state  <= S_READ;
`ifdef MEM_ARB_RR_EN
                        r_rr_if  <= 1'b0;
`endif
                    end else if (w_grant_lsb) begin
                        r_is_if <= 1'b0;
                        r_base  <= w_eaddr;
                        r_n     <= w_lsb_n;
                        r_f3    <= lsb_opt[2:0];
                        r_val   <= lsb_val;
                        r_tag   <= lsb_val[3:0];
                        r_cap   <= 2'd0;
                        r_first <= 1'b1;
                        r_mem_a <= w_eaddr;
`ifdef MEM_ARB_RR_EN
                        r_rr_if <= 1'b1;
`endif
                        if (w_lsb_store) begin
                            r_state <= S_WRITE;
                            if (w_io_grant) begin
                                r_mem_wr <= 1'b0;
                                r_idx    <= 3'd0;
                            end else begin
                                r_mem_wr   <= 1'b1;
                                r_mem_dout <= lsb_val[7:0];
                                r_idx      <= 3'd1;
                            end
                        end else begin
                            r_state  <= S_READ;
                            r_mem_wr <= 1'b0;
                            r_idx    <= 3'd1;
                        end
                    end
                end
                S_READ: begin
                    if (clear) begin
                        r_state  <= S_IDLE;
                        r_mem_wr <= 1'b0;
                    end else begin
                        if (r_idx < r_n) begin
                            r_mem_a <= w_next_addr;
                            r_idx   <= r_idx + 3'd1;
                        end
                        // RAM data lags the address by one cycle, so the first edge captures nothing.
                        if (r_first) begin
                            r_first <= 1'b0;
                        end else begin
                            r_buf <= w_buf_cap;
                            r_cap <= r_cap + 2'd1;
                            if ({1'b0, r_cap} == r_n - 3'd1) begin
                                r_state <= S_DONE;
                                if (r_is_if) begin
                                    r_if_done <= 1'b1;
                                    r_if_data <= w_buf_cap;
                                end else begin
                                    r_lsb_done <= 1'b1;
                                    r_cdb_ok   <= 1'b1;
                                    r_cdb_en   <= r_tag;
                                    r_cdb_val  <= w_ext;
                                end
                            end
                        end
                    end
                end
                S_WRITE: begin
                    if (r_idx == r_n) begin
                        r_mem_wr   <= 1'b0;
                        r_state    <= S_DONE;
                        r_lsb_done <= 1'b1;
                    end else begin
                        r_mem_a <= w_next_addr;
                        if (w_io_next) begin
                            r_mem_wr <= 1'b0;
                        end else begin
                            r_mem_wr   <= 1'b1;
                            r_mem_dout <= w_store_byte;
                            r_idx      <= r_idx + 3'd1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter with a registered byte RAM model.
`default_nettype none

module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b1;
    logic        clear = 1'b0;
    logic        io_buffer_full = 1'b0;
    logic [7:0]  mem_din = 8'd0;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'd0;
    logic        if_done;
    logic [31:0] if_data;
    logic        lsb_req = 1'b0;
    logic [31:0] lsb_addr = 32'd0;
    logic [31:0] lsb_imm = 32'd0;
    logic [31:0] lsb_val = 32'd0;
    logic [5:0]  lsb_opt = 6'd0;
    logic        lsb_done;
    logic        cdb_ok;
    logic [3:0]  cdb_en;
    logic [31:0] cdb_val;

    int total = 0;
    int bad = 0;

    logic [7:0]  ram [0:262143];
    logic        tb_we = 1'b0;
    logic [17:0] tb_wa = 18'd0;
    logic [7:0]  tb_wd = 8'd0;

    mem_arbiter dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clear(clear), .io_buffer_full(io_buffer_full),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
        .lsb_req(lsb_req), .lsb_addr(lsb_addr), .lsb_imm(lsb_imm), .lsb_val(lsb_val),
        .lsb_opt(lsb_opt), .lsb_done(lsb_done), .cdb_ok(cdb_ok), .cdb_en(cdb_en),
        .cdb_val(cdb_val)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_wr) ram[mem_a[17:0]] <= mem_dout;
        else if (tb_we) ram[tb_wa] <= tb_wd;
        mem_din <= ram[mem_a[17:0]];
    end

    task automatic poke(input logic [17:0] a, input logic [7:0] d);
        tb_we = 1'b1; tb_wa = a; tb_wd = d;
        @(negedge clk);
        tb_we = 1'b0;
    endtask

    // Fetch runner: k counts negedges after the sampling edge; 0 in cyc means no done seen.
    task automatic run_if(input logic [31:0] addr, input int rdy_off, input int clr_at,
                          output int cyc, output logic [31:0] data, output int plen);
        cyc = 0; data = 32'd0; plen = 0;
        if_addr = addr; if_req = 1'b1;
        if (rdy_off > 0) rdy = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == rdy_off) rdy = 1'b1;
            if (k == clr_at) begin clear = 1'b1; if_req = 1'b0; end
            else clear = 1'b0;
            if (if_done) plen++;
            if (if_done && cyc == 0) begin cyc = k; data = if_data; if_req = 1'b0; end
        end
        clear = 1'b0; if_req = 1'b0;
    endtask

    task automatic run_lsb(input logic [5:0] opt, input logic [31:0] addr, input logic [31:0] imm,
                           input logic [31:0] val, input int full_n, input int clr_at,
                           output int cyc, output logic [15:0] wtr, output logic [31:0] cval,
                           output logic [3:0] ctag, output logic cok);
        cyc = 0; wtr = 16'd0; cval = 32'd0; ctag = 4'd0; cok = 1'b0;
        lsb_opt = opt; lsb_addr = addr; lsb_imm = imm; lsb_val = val; lsb_req = 1'b1;
        io_buffer_full = (full_n > 0);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == full_n) io_buffer_full = 1'b0;
            clear = (k == clr_at);
            if (k < 16) wtr[k] = mem_wr;
            if (lsb_done && cyc == 0) begin
                cyc = k; cval = cdb_val; ctag = cdb_en; cok = cdb_ok; lsb_req = 1'b0;
            end
        end
        clear = 1'b0; lsb_req = 1'b0; io_buffer_full = 1'b0;
    endtask

    task automatic test_reset;
        if_req = 1'b1; lsb_req = 1'b1; lsb_opt = 6'b111010; lsb_val = 32'hFFFFFFFF;
        repeat (3) @(negedge clk);
        total++;
        if ({mem_a, mem_dout, mem_wr} !== 41'd0) begin
            bad++; $display("FAIL reset_mem got a=%h d=%h wr=%b want 0", mem_a, mem_dout, mem_wr);
        end
        total++;
        if ({if_done, lsb_done, cdb_ok, cdb_en} !== 7'd0) begin
            bad++; $display("FAIL reset_pulses got %b%b%b en=%h want 0", if_done, lsb_done, cdb_ok, cdb_en);
        end
        total++;
        if ({if_data, cdb_val} !== 64'd0) begin
            bad++; $display("FAIL reset_data got if=%h cdb=%h want 0", if_data, cdb_val);
        end
        if_req = 1'b0; lsb_req = 1'b0;
        poke(18'h100, 8'h13); poke(18'h101, 8'h05); poke(18'h102, 8'h10); poke(18'h103, 8'h00);
        poke(18'h20, 8'h80);
        poke(18'h40, 8'h00); poke(18'h41, 8'h00); poke(18'h42, 8'h00); poke(18'h43, 8'h00);
        poke(18'h50, 8'h34); poke(18'h51, 8'h92);
        poke(18'h60, 8'h00); poke(18'h61, 8'h00); poke(18'h62, 8'h00); poke(18'h63, 8'h00);
        poke(18'h30000, 8'h00);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fetch;
        int cyc; int plen; logic [31:0] d;
        run_if(32'h100, 0, 0, cyc, d, plen);
        total++;
        if (cyc != 6) begin bad++; $display("FAIL fetch_latency got %0d want 6", cyc); end
        total++;
        if (d !== 32'h00100513) begin bad++; $display("FAIL fetch_data got %h want 00100513", d); end
        total++;
        if (plen != 1) begin bad++; $display("FAIL fetch_pulse got %0d want 1", plen); end
    endtask

    task automatic test_loads;
        int cyc; logic [15:0] w; logic [31:0] v; logic [3:0] t; logic ok;
        run_lsb(6'b101000, 32'h1C, 32'd4, 32'd7, 0, 0, cyc, w, v, t, ok);
        total++;
        if (cyc != 3 || ok !== 1'b1 || t !== 4'd7 || v !== 32'hFFFFFF80) begin
            bad++; $display("FAIL lb got cyc=%0d ok=%b tag=%h val=%h want 3 1 7 ffffff80", cyc, ok, t, v);
        end
        run_lsb(6'b101100, 32'h1C, 32'd4, 32'd5, 0, 0, cyc, w, v, t, ok);
        total++;
        if (ok !== 1'b1 || t !== 4'd5 || v !== 32'h00000080) begin
            bad++; $display("FAIL lbu got ok=%b tag=%h val=%h want 1 5 00000080", ok, t, v);
        end
        run_lsb(6'b101001, 32'h50, 32'd0, 32'd2, 0, 0, cyc, w, v, t, ok);
        total++;
        if (cyc != 4 || v !== 32'hFFFF9234) begin
            bad++; $display("FAIL lh got cyc=%0d val=%h want 4 ffff9234", cyc, v);
        end
        run_lsb(6'b101101, 32'h52, 32'hFFFFFFFE, 32'd9, 0, 0, cyc, w, v, t, ok);
        total++;
        if (v !== 32'h00009234 || t !== 4'd9) begin
            bad++; $display("FAIL lhu got val=%h tag=%h want 00009234 9", v, t);
        end
    endtask

    task automatic test_sh_lw;
        int cyc; logic [15:0] w; logic [31:0] v; logic [3:0] t; logic ok;
        run_lsb(6'b111001, 32'h40, 32'd0, 32'hDEADBEEF, 0, 0, cyc, w, v, t, ok);
        total++;
        if (cyc != 3 || w[3:1] !== 3'b011) begin
            bad++; $display("FAIL sh_timing got cyc=%0d wr=%b want 3 011", cyc, w[3:1]);
        end
        total++;
        if (ram[18'h40] !== 8'hEF || ram[18'h41] !== 8'hBE || ram[18'h42] !== 8'h00) begin
            bad++; $display("FAIL sh_ram got %h %h %h want ef be 00", ram[18'h40], ram[18'h41], ram[18'h42]);
        end
        run_lsb(6'b101010, 32'h40, 32'd0, 32'd11, 0, 0, cyc, w, v, t, ok);
        total++;
        if (cyc != 6 || v !== 32'h0000BEEF || t !== 4'd11) begin
            bad++; $display("FAIL lw got cyc=%0d val=%h tag=%h want 6 0000beef b", cyc, v, t);
        end
    endtask

    task automatic test_io_stall;
        int cyc; logic [15:0] w; logic [31:0] v; logic [3:0] t; logic ok;
        run_lsb(6'b111000, 32'h30000, 32'd0, 32'h000000A5, 3, 0, cyc, w, v, t, ok);
        total++;
        if (cyc != 5 || w[5:1] !== 5'b01000) begin
            bad++; $display("FAIL io_stall got cyc=%0d wr=%b want 5 01000", cyc, w[5:1]);
        end
        total++;
        if (ram[18'h30000] !== 8'hA5) begin
            bad++; $display("FAIL io_ram got %h want a5", ram[18'h30000]);
        end
    endtask

    task automatic test_flush;
        int cyc; int plen; logic [31:0] d; logic [15:0] w; logic [31:0] v; logic [3:0] t; logic ok;
        run_if(32'h100, 0, 2, cyc, d, plen);
        total++;
        if (cyc != 0 || plen != 0) begin
            bad++; $display("FAIL flush_if got done_at=%0d pulses=%0d want 0 0", cyc, plen);
        end
        run_if(32'h100, 0, 0, cyc, d, plen);
        total++;
        if (cyc != 6 || d !== 32'h00100513) begin
            bad++; $display("FAIL flush_refetch got cyc=%0d data=%h want 6 00100513", cyc, d);
        end
        run_lsb(6'b111010, 32'h60, 32'd0, 32'h11223344, 0, 2, cyc, w, v, t, ok);
        total++;
        if (cyc != 5 || w[5:1] !== 5'b01111) begin
            bad++; $display("FAIL flush_sw got cyc=%0d wr=%b want 5 01111", cyc, w[5:1]);
        end
        total++;
        if ({ram[18'h63], ram[18'h62], ram[18'h61], ram[18'h60]} !== 32'h11223344) begin
            bad++; $display("FAIL flush_sw_ram got %h%h%h%h want 11223344",
                            ram[18'h63], ram[18'h62], ram[18'h61], ram[18'h60]);
        end
    endtask

    task automatic test_rdy_freeze;
        int cyc; int plen; logic [31:0] d;
        run_if(32'h100, 3, 0, cyc, d, plen);
        total++;
        if (cyc != 9 || d !== 32'h00100513 || plen != 1) begin
            bad++; $display("FAIL rdy_freeze got cyc=%0d data=%h pulses=%0d want 9 00100513 1", cyc, d, plen);
        end
    endtask

    task automatic test_tie;
        int order [4]; int exp_o [4]; int n; int round;
        n = 0; round = 0;
`ifdef MEM_ARB_RR_EN
        exp_o = '{0, 1, 0, 1};
`else
        exp_o = '{1, 0, 1, 0};
`endif
        for (int i = 0; i < 4; i++) order[i] = -1;
        if_addr = 32'h100;
        lsb_opt = 6'b101010; lsb_addr = 32'h100; lsb_imm = 32'd0; lsb_val = 32'd3;
        if_req = 1'b1; lsb_req = 1'b1;
        for (int k = 0; k < 80 && n < 4; k++) begin
            @(negedge clk);
            if (if_done && n < 4) begin order[n] = 0; n++; if_req = 1'b0; end
            if (lsb_done && n < 4) begin order[n] = 1; n++; lsb_req = 1'b0; end
            if (n == 2 && round == 0) begin
                round = 1;
                @(negedge clk);
                if_req = 1'b1; lsb_req = 1'b1;
            end
        end
        if_req = 1'b0; lsb_req = 1'b0;
        total++;
        if (n != 4) begin bad++; $display("FAIL tie_count got %0d grants want 4", n); end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (order[i] != exp_o[i]) begin
                bad++; $display("FAIL tie_order[%0d] got %0d want %0d (0=IF 1=LSB)", i, order[i], exp_o[i]);
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid;
        lsb_opt = 6'b111010; lsb_addr = 32'h70; lsb_imm = 32'd0; lsb_val = 32'hCAFEF00D;
        lsb_req = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (mem_wr !== 1'b1) begin bad++; $display("FAIL mid_active got wr=%b want 1", mem_wr); end
        rst = 1'b0; lsb_req = 1'b0;
        #1;
        total++;
        if ({mem_wr, mem_a, mem_dout} !== 41'd0) begin
            bad++; $display("FAIL mid_reset got wr=%b a=%h d=%h want 0", mem_wr, mem_a, mem_dout);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_loads();
        test_sh_lw();
        test_io_stall();
        test_flush();
        test_rdy_freeze();
        test_tie();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Sole owner of the byte-wide RAM/IO port. Arbitrates between instruction fetch (word reads) and the load/store buffer (sized loads and stores). Sequences multi-byte accesses one byte per cycle. Returns fetch words to IF and broadcasts load results on a dedicated CDB slot tagged with the ROB entry. Sits between IF/LSB and the top-level memory pins.

## Interface
Parameters:
- ADDR_W, 32, RAM address width.
- IO_HI, 2'b11, value of addr[17:16] that marks the IO region.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- rdy  in  1  global enable; 0 freezes all state.
- clear  in  1  misprediction flush.
- io_buffer_full  in  1  IO write back-pressure.
- mem_din  in  8  RAM read byte.
- mem_dout  out  8  RAM write byte.
- mem_a  out  32  RAM byte address.
- mem_wr  out  1  1 = write.
- if_req  in  1  fetch request, level, held until if_done.
- if_addr  in  32  fetch address.
- if_done  out  1  one-cycle pulse; if_data valid.
- if_data  out  32  fetched word, little-endian.
- lsb_req  in  1  LSB request, level, held until lsb_done.
- lsb_addr, lsb_imm  in  32  effective address = lsb_addr + lsb_imm.
- lsb_val  in  32  store data; for loads, [3:0] = ROB tag.
- lsb_opt  in  6  [5:3]=101 load, 111 store; [2:0] funct3.
- lsb_done  out  1  one-cycle pulse, load or store finished.
- cdb_ok  out  1  load result broadcast, one cycle, same cycle as lsb_done.
- cdb_en  out  4  ROB tag of the load.
- cdb_val  out  32  extended load value.

## Operation
- FSM states: IDLE, READ, WRITE, DONE.
- IDLE, requests sampled:
  - One pending: grant it.
  - Both pending: arbitrate per Configuration.
- On grant:
  - Latch the effective address and byte count n.
  - n = 1 for funct3 000/100, 2 for 001/101, 4 for 010.
  - IF is always n = 4.
  - Drive the first mem_a.
  - Go to READ (IF or load) or WRITE (store).
- READ:
  - Issue addresses a..a+n-1 on consecutive cycles.
  - Capture mem_din one cycle after each address into byte lane i.
  - After the last capture, go to DONE.
- WRITE:
  - Drive mem_a = a+i, mem_dout = val byte i, mem_wr = 1 for i = 0..n-1.
  - If the address is in the IO region and io_buffer_full = 1: stall with mem_wr = 0 and the index held.
- DONE (one cycle):
  - Pulse if_done, or lsb_done (plus cdb_ok for loads).
  - Requests are ignored in this cycle, because the requester drops its level at the next edge.
  - Return to IDLE.
- Load extension:
  - 000: sign-extend byte. 001: sign-extend half.
  - 100, 101: zero-extend.
  - 010: pass through.
- clear:
  - Aborts an in-progress IF or load: mem_wr = 0 next edge, state goes to IDLE, no done pulse.
  - A store in progress always completes; stores are committed.
  - A done pulse already registered is not retracted.
- rdy = 0: all registers hold, including outputs.

## Timing
- Reset values:
  - mem_a = 0, mem_dout = 0, mem_wr = 0.
  - if_done = lsb_done = cdb_ok = 0.
  - if_data = cdb_val = 0, cdb_en = 0.
  - FSM = IDLE, round-robin pointer = IF.
- Read of n bytes, request sampled at edge E0:
  - Addresses driven after E0..E0+n-1.
  - Done pulse high after edge E0+n+1.
  - Word fetch: 6 cycles request-to-done.
- Write of n bytes, sampled at E0:
  - mem_wr high after E0..E0+n-1, plus any IO stall cycles.
  - Done pulse high after E0+n.
- Back-to-back throughput: one idle cycle (DONE) between accesses.
- Address increment wraps modulo 2^32.
- Reset asserted mid-access: immediate return to reset values. A partial store may remain in RAM.

## Configuration
- MEM_ARB_RR_EN defined: round-robin arbitration.
  - The requester granted last loses the next tie.
  - Pointer updates on every grant.
- MEM_ARB_RR_EN undefined: fixed priority, LSB wins every tie.
  - Keeps store drain latency minimal; IF may starve under continuous LSB traffic.

## Test plan
- Word fetch: RAM[0x100..0x103] = 13,05,10,00; if_req with if_addr = 0x100 → if_data = 0x00100513, if_done high for exactly one cycle, 6 cycles after the request is sampled.
- LB/LBU: RAM[0x20] = 0x80.
  - Load opt 101000, addr 0x1C, imm 4, val 7 → cdb_ok, cdb_en = 7, cdb_val = 0xFFFFFF80.
  - Opt 101100 → cdb_val = 0x00000080.
- SH then LW: store opt 111001, addr 0x40, val 0xDEADBEEF → RAM[0x40] = EF, RAM[0x41] = BE, 2 write cycles. A following word load at 0x40 returns 0x0000BEEF.
- Tie: if_req and lsb_req rise together twice in a row.
  - RR build: grant order IF, LSB, IF.
  - Non-RR build: LSB every tie.
- IO stall: SB to 0x30000 with io_buffer_full held high 3 cycles → mem_wr stays 0 for those 3 cycles, then one write, then lsb_done.
- Flush: clear during the 2nd byte of an IF fetch → no if_done, FSM in IDLE next cycle. clear during a SW → all 4 bytes written and lsb_done pulses.
